rr_arbiter4: RTL and testbench
==============================

Name: rr_arbiter4

Overview:
- Four-requester round-robin arbiter for one shared resource. Output stage is the team's 2-to-4 one-hot decode.
- Grants the resource to one requester at a time and holds the grant while that request stays high.
- Forces release after MAX_HOLD cycles, then rotates priority.
- Sits between four requesting blocks and any resource whose select is a one-hot or 2-bit index with enable.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles a single grant may stay high. Legal range 1..255.
- CNT_W, 8, width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  arbiter enable. Low forces release and blocks new grants.
- req  input  4  level requests; bit i = requester i. Held high while the resource is in use.
- grant  output  4  one-hot grant, registered; 4'b0000 when none.
- grant_idx  output  2  encoded index of the current or most recent grant.
- grant_valid  output  1  high whenever grant is non-zero.
- timeout  output  1  one-cycle pulse when a grant is forcibly ended by the hold limit.

Behaviour:
- Reset (sync, rst=1 at an edge) sets:
  - state=IDLE, grant=4'b0000, grant_idx=2'b00, grant_valid=0, timeout=0.
  - Priority pointer ptr=0; hold_cnt=0.
- rst has priority over all other logic. Asserting rst mid-grant drops grant at that edge, with no timeout pulse.
- Arbitration function:
  - Search req starting at bit ptr, upward, wrapping 3->0.
  - The first set bit wins, giving index w.
- State IDLE:
  - If en=1 and req!=0 at an edge: grant=one-hot(w), grant_idx=w, grant_valid=1, hold_cnt=1, go to GRANT.
  - Otherwise stay in IDLE with outputs at zero.
  - Latency: request sampled at edge k gives grant visible from edge k+1 (one cycle).
- State GRANT: release conditions are evaluated at each edge, in priority order:
  - en=0: release, timeout=0.
  - req[grant_idx]=0: release, timeout=0.
  - hold_cnt==MAX_HOLD: release, timeout=1 for exactly one cycle, aligned with grant going to 0.
  - None of the above: hold grant and increment hold_cnt.
- On release:
  - grant=0, grant_valid=0, hold_cnt=0, ptr=grant_idx+1 mod 4, go to GAP.
  - grant_idx keeps its last value.
- Requests from other requesters during GRANT are ignored; only req[grant_idx] is observed.
- A grant is therefore high for at most MAX_HOLD consecutive cycles.
- State GAP: exactly one cycle with grant=0 (bus turnaround). At its end:
  - If en=1 and req!=0, arbitrate as in IDLE using the updated ptr and go to GRANT.
  - Otherwise go to IDLE.
- timeout is 0 in every cycle except the one described above.
- grant is always one-hot or zero, and grant_valid==|grant.
- With MAX_HOLD=1, every grant lasts one cycle. A requester holding req continuously then cannot be re-granted until every other active requester has been served once.
- en=0 in IDLE or GAP: no grant is issued and ptr is unchanged.

Test Plan:
- Reset: MAX_HOLD=4, rst=1 for 2 cycles with req=4'b1111 -> grant=0000, grant_valid=0, timeout=0 throughout. Drop rst -> first grant 0001, grant_idx=0, one cycle later.
- Single request: req=0100 sampled at edge k, held 3 cycles, then dropped -> grant=0100 on cycles k+1..k+3. grant=0000 at the next edge, one GAP cycle, then IDLE. timeout never asserts.
- Round robin with timeouts: MAX_HOLD=4, req=1111 constant, in this order:
  - grant 0001 for 4 cycles;
  - timeout pulse with grant=0 and 1 GAP cycle;
  - then 0010 x4, 0100 x4, 1000 x4, 0001;
  - exactly 4 timeout pulses over one full rotation.
- Pointer wrap: after a grant to requester 2 ends (ptr=3), apply req=1001 -> grant 1000 (grant_idx=3). After its release, with req=1001 still present -> grant 0001.
- Enable drop: grant 0010 active, en=0 for 3 cycles -> grant=0000 at the next edge, timeout=0, no new grant while en=0. Restore en with req=0010 -> grant 0100 has priority if requested, otherwise 0010 after the GAP/IDLE arbitration.
- Reset mid-grant: grant 1000 active, rst=1 for one cycle -> grant=0000 and grant_idx=0 at that edge. With req=1010 afterwards -> next grant 0010 (ptr back to 0).

Source files
------------

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with hold limit and one-cycle turnaround gap.
// Grant is registered one-hot; grant_idx remembers the most recent winner.
module rr_arbiter4 #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] grant_idx,
    output logic       grant_valid,
    output logic       timeout
);
    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);

    state_t           state_reg, state_next;
    logic [3:0]       grant_reg, grant_next;
    logic [1:0]       idx_reg, idx_next;
    logic [1:0]       ptr_reg, ptr_next;
    logic             valid_reg, valid_next;
    logic             timeout_reg, timeout_next;
    logic [CNT_W-1:0] hold_cnt_reg, hold_cnt_next;

    // Requests rotated so that offset 0 is the current priority holder.
    logic [1:0] rot_idx [4];
    logic [3:0] req_rot;
    logic [1:0] win_idx;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rotate
            assign rot_idx[gi] = ptr_reg + 2'(gi);
            assign req_rot[gi] = req[rot_idx[gi]];
        end
    endgenerate

    always_comb begin
        win_idx = ptr_reg;
        for (int i = 3; i >= 0; i--) begin
            if (req_rot[i]) win_idx = rot_idx[i];
        end
    end

    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        ptr_next      = ptr_reg;
        valid_next    = 1'b0;
        timeout_next  = 1'b0;
        hold_cnt_next = '0;
        case (state_reg)
            IDLE, GAP: begin
                if (en && (req != 4'b0000)) begin
                    state_next    = GRANT;
                    idx_next      = win_idx;
                    valid_next    = 1'b1;
                    hold_cnt_next = CNT_W'(1);
                end else begin
                    state_next = IDLE;
                end
            end
            GRANT: begin
                if (!en || !req[idx_reg] || (hold_cnt_reg == HOLD_LIMIT)) begin
                    // Voluntary release takes precedence over the hold limit.
                    timeout_next = en && req[idx_reg];
                    state_next   = GAP;
                    ptr_next     = idx_reg + 2'd1;
                end else begin
                    valid_next    = 1'b1;
                    hold_cnt_next = hold_cnt_reg + CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output stage: 2-to-4 one-hot decode of the next grant index.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_decode
            assign grant_next[gi] = valid_next && (idx_next == 2'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            grant_reg    <= 4'b0000;
            idx_reg      <= 2'b00;
            ptr_reg      <= 2'b00;
            valid_reg    <= 1'b0;
            timeout_reg  <= 1'b0;
            hold_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            grant_reg    <= grant_next;
            idx_reg      <= idx_next;
            ptr_reg      <= ptr_next;
            valid_reg    <= valid_next;
            timeout_reg  <= timeout_next;
            hold_cnt_reg <= hold_cnt_next;
        end
    end

    assign grant       = grant_reg;
    assign grant_idx   = idx_reg;
    assign grant_valid = valid_reg;
    assign timeout     = timeout_reg;
endmodule

// File: tb/tb_rr_arbiter4.sv
// Bench for rr_arbiter4: directed vector table, then random traffic against an owner/pointer model.
module tb_rr_arbiter4;
    localparam int MAXH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    int pass_cnt  = 0;
    int total_cnt = 0;

    rr_arbiter4 #(.MAX_HOLD(MAXH), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .req        (req),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic [3:0] req;
        logic [3:0] g;
        logic [1:0] idx;
        logic       to;
    } vec_t;

    vec_t vecs[$];

    // Reference: who owns the resource, for how long, and where priority starts.
    int m_owner = -1;
    int m_held  = 0;
    int m_ptr   = 0;
    int m_idx   = 0;
    bit m_to    = 1'b0;

    function automatic void add(int n, logic r, logic e, logic [3:0] q,
                                logic [3:0] g, logic [1:0] ix, logic t);
        for (int i = 0; i < n; i++) vecs.push_back('{r, e, q, g, ix, t});
    endfunction

    task automatic check(string name, int cyc, logic [3:0] act, logic [3:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s @%0d: got %0h, expected %0h", name, cyc, act, exp);
    endtask

    task automatic model_edge(logic r, logic e, logic [3:0] q);
        m_to = 1'b0;
        if (r) begin
            m_owner = -1; m_held = 0; m_ptr = 0; m_idx = 0;
        end else if (m_owner >= 0) begin
            if (!e || !q[m_owner] || m_held == MAXH) begin
                m_to    = e && q[m_owner];
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
                m_held  = 0;
            end else begin
                m_held++;
            end
        end else if (e && q != 4'b0000) begin
            for (int k = 0; k < 4; k++) begin
                if (m_owner < 0 && q[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
            end
            m_idx  = m_owner;
            m_held = 1;
        end
    endtask

    task automatic step(logic r, logic e, logic [3:0] q);
        rst = r; en = e; req = q;
        @(posedge clk);
        model_edge(r, e, q);
        #1;
    endtask

    initial begin
        logic [3:0] cur_req;
        logic [3:0] m_grant;
        logic       cur_en, cur_rst;

        // Reset with all requests, then full rotation with hold-limit timeouts.
        add(2, 1, 1, 4'b1111, 4'b0000, 2'd0, 0);
        add(4, 0, 1, 4'b1111, 4'b0001, 2'd0, 0);
        add(1, 0, 1, 4'b1111, 4'b0000, 2'd0, 1);
        add(4, 0, 1, 4'b1111, 4'b0010, 2'd1, 0);
        add(1, 0, 1, 4'b1111, 4'b0000, 2'd1, 1);
        add(4, 0, 1, 4'b1111, 4'b0100, 2'd2, 0);
        add(1, 0, 1, 4'b1111, 4'b0000, 2'd2, 1);
        add(4, 0, 1, 4'b1111, 4'b1000, 2'd3, 0);
        add(1, 0, 1, 4'b1111, 4'b0000, 2'd3, 1);
        add(1, 0, 1, 4'b1111, 4'b0001, 2'd0, 0);
        // Voluntary release, then single request held three cycles.
        add(2, 0, 1, 4'b0000, 4'b0000, 2'd0, 0);
        add(3, 0, 1, 4'b0100, 4'b0100, 2'd2, 0);
        add(2, 0, 1, 4'b0000, 4'b0000, 2'd2, 0);
        // Pointer wrap: ptr=3 so 1001 picks requester 3, then 0.
        add(4, 0, 1, 4'b1001, 4'b1000, 2'd3, 0);
        add(1, 0, 1, 4'b1001, 4'b0000, 2'd3, 1);
        add(1, 0, 1, 4'b1001, 4'b0001, 2'd0, 0);
        // Enable drop during grant 0010.
        add(1, 0, 1, 4'b0010, 4'b0000, 2'd0, 0);
        add(1, 0, 1, 4'b0010, 4'b0010, 2'd1, 0);
        add(3, 0, 0, 4'b0010, 4'b0000, 2'd1, 0);
        add(1, 0, 1, 4'b0010, 4'b0010, 2'd1, 0);
        // Reset mid-grant clears index and pointer.
        add(1, 0, 1, 4'b1000, 4'b0000, 2'd1, 0);
        add(1, 0, 1, 4'b1000, 4'b1000, 2'd3, 0);
        add(1, 1, 1, 4'b1010, 4'b0000, 2'd0, 0);
        add(1, 0, 1, 4'b1010, 4'b0010, 2'd1, 0);

        #2;
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].req);
            $display("vec %0d: rst=%b en=%b req=%b -> grant=%b idx=%0d valid=%b timeout=%b",
                     i, vecs[i].rst, vecs[i].en, vecs[i].req, grant, grant_idx, grant_valid, timeout);
            check("vec_grant",   i, grant, vecs[i].g);
            check("vec_idx",     i, {2'b00, grant_idx}, {2'b00, vecs[i].idx});
            check("vec_valid",   i, {3'b000, grant_valid}, {3'b000, (vecs[i].g != 4'b0000)});
            check("vec_timeout", i, {3'b000, timeout}, {3'b000, vecs[i].to});
        end

        // Random traffic against the model, starting from a clean reset.
        step(1, 0, 4'b0000);
        cur_req = 4'b0000;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 4) == 0) cur_req[b] = ~cur_req[b];
            end
            cur_en  = ($urandom_range(0, 9) != 0);
            cur_rst = ($urandom_range(0, 299) == 0);
            step(cur_rst, cur_en, cur_req);
            m_grant = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
            if (m_owner >= 0 && m_held == 1)
                $display("rand %0d: grant to %0d (req=%b)", c, m_owner, cur_req);
            check("rand_grant",   c, grant, m_grant);
            check("rand_idx",     c, {2'b00, grant_idx}, 4'(m_idx));
            check("rand_valid",   c, {3'b000, grant_valid}, {3'b000, (m_owner >= 0)});
            check("rand_timeout", c, {3'b000, timeout}, {3'b000, m_to});
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
